// File: rtl/game_ctrl_pkg.sv
// Shared mode encoding and small helpers for the game sequencer.
package game_ctrl_pkg;

    localparam int BITS_MODE = 3;

    typedef enum logic [BITS_MODE-1:0] {
        MODE_IDLE  = 3'd0,
        MODE_START = 3'd1,
        MODE_PLAY  = 3'd2,
        MODE_PAUSE = 3'd3,
        MODE_OVER  = 3'd4
    } mode_e;

    // Increment a speed level, holding at the ceiling
    function automatic logic [1:0] speed_inc(input logic [1:0] speed,
                                             input logic [1:0] max_speed);
        if (speed >= max_speed)
            return max_speed;
        else
            return speed + 2'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_bcd_counter4.sv
// 4-digit BCD incrementer that holds at 9999, with synchronous clear.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_clr,
    output logic [15:0] o_bcd
);

    logic [15:0] r_bcd;
    logic [15:0] w_next;

    // Ripple a +1 through the digits, wrapping each 9 to 0 and carrying on
    always_comb begin
        logic carry;
        w_next = r_bcd;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_bcd[i*4 +: 4] == 4'd9) begin
                    w_next[i*4 +: 4] = 4'd0;
                end else begin
                    w_next[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
    end

    // Count register: clear wins, saturate at 9999 so nothing wraps to 0000
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_bcd <= 16'h0000;
        else if (i_clr)
            r_bcd <= 16'h0000;
        else if (i_inc && (r_bcd != 16'h9999))
            r_bcd <= w_next;
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/game_ctrl.sv
// Tetris game sequencer: play-mode FSM, button edge detection, row score
// in BCD and fall-speed level derivation.
import game_ctrl_pkg::*;

module game_ctrl #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_SPEED       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pause_btn,
    input  logic                 restart_btn,
    input  logic                 spawn_blocked,
    input  logic                 get_score,
    output logic [BITS_MODE-1:0] mode,
    output logic                 game_start,
    output logic                 board_clear,
    output logic                 stack_commit_en,
    output logic [1:0]           fall_speed,
    output logic [15:0]          score_bcd,
    output logic [3:0]           lines_in_level
);

    localparam logic [3:0] L_LAST = 4'(LINES_PER_LEVEL - 1);
    localparam logic [1:0] S_MAX  = 2'(MAX_SPEED);

    logic  r_pause_q;
    logic  r_restart_q;
    logic  w_pause_rise;
    logic  w_restart_rise;
    mode_e r_state;
    logic  r_game_start;
    logic  r_board_clear;
    logic  [1:0] r_fall_speed;
    logic  [3:0] r_lines;
    logic  w_score_inc;
    logic  w_clr;

    // Previous button levels for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause_q   <= 1'b0;
            r_restart_q <= 1'b0;
        end else begin
            r_pause_q   <= pause_btn;
            r_restart_q <= restart_btn;
        end
    end

    assign w_pause_rise   = pause_btn & ~r_pause_q;
    assign w_restart_rise = restart_btn & ~r_restart_q;

    // Rows only count while playing, and a restart in the same cycle discards them
    assign w_score_inc = (r_state == MODE_PLAY) & get_score & ~w_restart_rise;
    assign w_clr       = (r_state == MODE_START);

    // Mode FSM with registered one-cycle board_clear / game_start pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= MODE_IDLE;
            r_game_start  <= 1'b0;
            r_board_clear <= 1'b0;
        end else begin
            r_game_start  <= 1'b0;
            r_board_clear <= 1'b0;
            case (r_state)
                MODE_IDLE: begin
                    if (w_restart_rise) begin
                        r_state       <= MODE_START;
                        r_board_clear <= 1'b1;
                    end
                end
                MODE_START: begin
                    r_state      <= MODE_PLAY;
                    r_game_start <= 1'b1;
                end
                MODE_PLAY: begin
                    if (w_restart_rise) begin
                        r_state       <= MODE_START;
                        r_board_clear <= 1'b1;
                    end else if (spawn_blocked) begin
                        r_state <= MODE_OVER;
                    end else if (w_pause_rise) begin
                        r_state <= MODE_PAUSE;
                    end
                end
                MODE_PAUSE: begin
                    if (w_restart_rise) begin
                        r_state       <= MODE_START;
                        r_board_clear <= 1'b1;
                    end else if (w_pause_rise) begin
                        r_state <= MODE_PLAY;
                    end
                end
                MODE_OVER: begin
                    if (w_restart_rise) begin
                        r_state       <= MODE_START;
                        r_board_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state <= MODE_IDLE;
                end
            endcase
        end
    end

    // Rows-per-level counter; each wrap bumps the fall speed up to its ceiling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lines      <= 4'd0;
            r_fall_speed <= 2'd0;
        end else if (w_clr) begin
            r_lines      <= 4'd0;
            r_fall_speed <= 2'd0;
        end else if (w_score_inc) begin
            if (r_lines >= L_LAST) begin
                r_lines      <= 4'd0;
                r_fall_speed <= speed_inc(r_fall_speed, S_MAX);
            end else begin
                r_lines <= r_lines + 4'd1;
            end
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_score_inc),
        .i_clr (w_clr),
        .o_bcd (score_bcd)
    );

    assign mode            = r_state;
    assign game_start      = r_game_start;
    assign board_clear     = r_board_clear;
    assign stack_commit_en = (r_state == MODE_PLAY);
    assign fall_speed      = r_fall_speed;
    assign lines_in_level  = r_lines;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus random stimulus
// against a behavioural model of the game rules.
import game_ctrl_pkg::*;

module tb_game_ctrl;

    localparam int LPL  = 10;
    localparam int MAXS = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 pause_btn;
    logic                 restart_btn;
    logic                 spawn_blocked;
    logic                 get_score;
    logic [BITS_MODE-1:0] mode;
    logic                 game_start;
    logic                 board_clear;
    logic                 stack_commit_en;
    logic [1:0]           fall_speed;
    logic [15:0]          score_bcd;
    logic [3:0]           lines_in_level;

    int checks   = 0;
    int failures = 0;

    game_ctrl #(.LINES_PER_LEVEL(LPL), .MAX_SPEED(MAXS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pause_btn       (pause_btn),
        .restart_btn     (restart_btn),
        .spawn_blocked   (spawn_blocked),
        .get_score       (get_score),
        .mode            (mode),
        .game_start      (game_start),
        .board_clear     (board_clear),
        .stack_commit_en (stack_commit_en),
        .fall_speed      (fall_speed),
        .score_bcd       (score_bcd),
        .lines_in_level  (lines_in_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_mode;      // uses MODE_* numeric values
    int m_score;     // rows cleared as a plain decimal number
    int m_lines;
    int m_speed;
    int m_gs;
    int m_bc;
    int m_pprev;
    int m_rprev;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = MODE_IDLE; m_score = 0; m_lines = 0; m_speed = 0;
            m_gs = 0; m_bc = 0; m_pprev = 0; m_rprev = 0;
        end else begin
            int pr, rr;
            pr = (pause_btn && !m_pprev) ? 1 : 0;
            rr = (restart_btn && !m_rprev) ? 1 : 0;
            m_pprev = pause_btn;
            m_rprev = restart_btn;
            m_gs = 0;
            m_bc = 0;
            if (m_mode == MODE_START) begin
                m_score = 0; m_lines = 0; m_speed = 0;
                m_mode = MODE_PLAY; m_gs = 1;
            end else if (rr != 0) begin
                m_mode = MODE_START; m_bc = 1;
            end else if (m_mode == MODE_PLAY) begin
                if (get_score) begin
                    if (m_score < 9999) m_score++;
                    m_lines++;
                    if (m_lines == LPL) begin
                        m_lines = 0;
                        if (m_speed < MAXS) m_speed++;
                    end
                end
                if (spawn_blocked) m_mode = MODE_OVER;
                else if (pr != 0) m_mode = MODE_PAUSE;
            end else if (m_mode == MODE_PAUSE) begin
                if (pr != 0) m_mode = MODE_PLAY;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk("mode",   32'(mode),            32'(m_mode));
        chk("gstart", 32'(game_start),      32'(m_gs));
        chk("bclear", 32'(board_clear),     32'(m_bc));
        chk("commit", 32'(stack_commit_en), 32'(m_mode == MODE_PLAY));
        chk("speed",  32'(fall_speed),      32'(m_speed));
        chk("score",  32'(score_bcd),       32'(to_bcd(m_score)));
        chk("lines",  32'(lines_in_level),  32'(m_lines));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pause_btn = 1'b0; restart_btn = 1'b0;
        spawn_blocked = 1'b0; get_score = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("lit_reset_mode",  32'(mode), 32'(MODE_IDLE));
        chk("lit_reset_score", 32'(score_bcd), 32'h0);

        // start-up: restart held 5 cycles
        restart_btn = 1'b1;
        tick(1);
        chk("lit_start_mode", 32'(mode), 32'(MODE_START));
        chk("lit_start_bc",   32'(board_clear), 32'd1);
        tick(1);
        chk("lit_play_mode", 32'(mode), 32'(MODE_PLAY));
        chk("lit_play_gs",   32'(game_start), 32'd1);
        chk("lit_play_sc",   32'(score_bcd), 32'h0);
        tick(1);
        chk("lit_gs_once", 32'(game_start), 32'd0);
        tick(2);
        restart_btn = 1'b0;

        // score and level
        get_score = 1'b1;
        tick(23);
        get_score = 1'b0;
        chk("lit_sc23",  32'(score_bcd), 32'h0023);
        chk("lit_sp23",  32'(fall_speed), 32'd2);
        chk("lit_ln23",  32'(lines_in_level), 32'd3);
        get_score = 1'b1;
        tick(30);
        get_score = 1'b0;
        chk("lit_sc53", 32'(score_bcd), 32'h0053);
        chk("lit_sp53", 32'(fall_speed), 32'd3);

        // saturation
        get_score = 1'b1;
        tick(9946);
        chk("lit_sc9999", 32'(score_bcd), 32'h9999);
        tick(2);
        get_score = 1'b0;
        chk("lit_sat", 32'(score_bcd), 32'h9999);
        chk("lit_sat_mode", 32'(mode), 32'(MODE_PLAY));

        // restart from PLAY clears everything
        restart_btn = 1'b1;
        tick(2);
        restart_btn = 1'b0;
        chk("lit_rs_score", 32'(score_bcd), 32'h0);
        chk("lit_rs_speed", 32'(fall_speed), 32'd0);

        // pause
        pause_btn = 1'b1;
        tick(1);
        chk("lit_pause_mode",   32'(mode), 32'(MODE_PAUSE));
        chk("lit_pause_commit", 32'(stack_commit_en), 32'd0);
        get_score = 1'b1;
        tick(3);
        get_score = 1'b0;
        chk("lit_pause_score", 32'(score_bcd), 32'h0);
        pause_btn = 1'b0;
        tick(1);
        pause_btn = 1'b1;
        tick(1);
        pause_btn = 1'b0;
        chk("lit_resume_mode", 32'(mode), 32'(MODE_PLAY));
        chk("lit_resume_gs",   32'(game_start), 32'd0);

        // game over with simultaneous score
        get_score = 1'b1;
        tick(41);
        chk("lit_sc41", 32'(score_bcd), 32'h0041);
        spawn_blocked = 1'b1;
        tick(1);
        spawn_blocked = 1'b0;
        get_score = 1'b0;
        chk("lit_over_score", 32'(score_bcd), 32'h0042);
        chk("lit_over_mode",  32'(mode), 32'(MODE_OVER));
        pause_btn = 1'b1;
        tick(1);
        pause_btn = 1'b0;
        chk("lit_over_pause", 32'(mode), 32'(MODE_OVER));
        restart_btn = 1'b1;
        tick(1);
        chk("lit_over_start", 32'(mode), 32'(MODE_START));
        tick(1);
        restart_btn = 1'b0;
        chk("lit_over_play",  32'(mode), 32'(MODE_PLAY));
        chk("lit_over_clr",   32'(score_bcd), 32'h0);

        // mid-operation asynchronous reset in PAUSE
        get_score = 1'b1;
        tick(107);
        get_score = 1'b0;
        pause_btn = 1'b1;
        tick(1);
        pause_btn = 1'b0;
        chk("lit_pre_rst_score", 32'(score_bcd), 32'h0107);
        chk("lit_pre_rst_mode",  32'(mode), 32'(MODE_PAUSE));
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_arst_mode",  32'(mode), 32'(MODE_IDLE));
        chk("lit_arst_score", 32'(score_bcd), 32'h0);
        chk("lit_arst_speed", 32'(fall_speed), 32'd0);
        chk("lit_arst_lines", 32'(lines_in_level), 32'd0);
        chk("lit_arst_flags", 32'({game_start, board_clear, stack_commit_en}), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // randomized play
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(11) == 0) restart_btn = ~restart_btn;
            get_score     = 1'($urandom_range(1));
            spawn_blocked = ($urandom_range(24) == 0);
            tick(1);
        end
        get_score = 1'b0;
        spawn_blocked = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
